// File: rtl/coherence_ctrl.sv
// Dual-core MESI coherence controller: arbitrates core intents, keeps a per-line
// directory, recalls dirty lines through copy-back and fills from main memory.
module coherence_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_intent_1,
  input  logic              rd_intent_2,
  input  logic              wr_intent_1,
  input  logic              wr_intent_2,
  input  logic [ADDR_W-1:0] addr_core_1,
  input  logic [ADDR_W-1:0] addr_core_2,
  output logic              copy_back_1,
  output logic              copy_back_2,
  input  logic              cb_ack_1,
  input  logic              cb_ack_2,
  input  logic [DATA_W-1:0] cb_data_1,
  input  logic [DATA_W-1:0] cb_data_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic              grant_1,
  output logic              grant_2,
  output logic              ex_or_shared_1,
  output logic              ex_or_shared_2,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_rd,
  output logic              main_mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] RECALL  = 3'd2;
  localparam logic [2:0] WB      = 3'd3;
  localparam logic [2:0] RD      = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam int LINES = 2 ** ADDR_W;

  // req/rr encode a core as 0 = core 1, 1 = core 2
  logic [2:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] wb_q, wb_d;
  logic [1:0]        dir1_q [LINES];
  logic [1:0]        dir1_d [LINES];
  logic [1:0]        dir2_q [LINES];
  logic [1:0]        dir2_d [LINES];

  logic       any_1, any_2, pick_2;
  logic [1:0] other_st;
  logic       ex_now;

  assign any_1    = rd_intent_1 | wr_intent_1;
  assign any_2    = rd_intent_2 | wr_intent_2;
  assign pick_2   = any_2 & (~any_1 | rr_q);
  assign other_st = req_q ? dir1_q[addr_q] : dir2_q[addr_q];
  assign ex_now   = wr_q | (other_st == ST_I);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    wb_d    = wb_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;
    case (state_q)
      IDLE: begin
        if (any_1 | any_2) begin
          req_d   = pick_2;
          addr_d  = pick_2 ? addr_core_2 : addr_core_1;
          wr_d    = pick_2 ? wr_intent_2 : wr_intent_1;
          state_d = ARB;
        end
      end
      ARB:     state_d = (other_st == ST_M) ? RECALL : RD;
      RECALL: begin
        if (req_q ? cb_ack_1 : cb_ack_2) begin
          wb_d    = req_q ? cb_data_1 : cb_data_2;
          state_d = WB;
        end
      end
      WB:      state_d = RD;
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        fill_d  = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        // A write takes ownership; a read is exclusive only if the other core holds nothing
        if (wr_q) begin
          dir1_d[addr_q] = req_q ? ST_I : ST_M;
          dir2_d[addr_q] = req_q ? ST_M : ST_I;
        end else if (other_st == ST_I) begin
          if (req_q) dir2_d[addr_q] = ST_E;
          else       dir1_d[addr_q] = ST_E;
        end else begin
          dir1_d[addr_q] = ST_S;
          dir2_d[addr_q] = ST_S;
        end
        rr_d    = ~rr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      fill_q  <= '0;
      wb_q    <= '0;
      for (int i = 0; i < LINES; i++) begin
        dir1_q[i] <= ST_I;
        dir2_q[i] <= ST_I;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      wb_q    <= wb_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
    end
  end

  assign copy_back_1    = (state_q == RECALL) & req_q;
  assign copy_back_2    = (state_q == RECALL) & ~req_q;
  assign grant_1        = (state_q == DONE) & ~req_q;
  assign grant_2        = (state_q == DONE) & req_q;
  assign ex_or_shared_1 = grant_1 & ex_now;
  assign ex_or_shared_2 = grant_2 & ex_now;
  // Stall drops with reset so a core never sees a stall from an aborted request
  assign stall_1        = ~reset & any_1 & ~grant_1;
  assign stall_2        = ~reset & any_2 & ~grant_2;
  assign fill_data      = fill_q;
  assign mem_rd         = (state_q == RD);
  assign main_mem_wr    = (state_q == WB);
  assign mem_addr       = addr_q;
  assign mem_wdata      = wb_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: memory and copy-back responders, a grant scoreboard
// fed by the request drivers, and directed coherence scenarios.
module tb_coherence_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_intent_1, rd_intent_2, wr_intent_1, wr_intent_2;
  logic [ADDR_W-1:0] addr_core_1, addr_core_2;
  logic              copy_back_1, copy_back_2;
  logic              cb_ack_1, cb_ack_2;
  logic [DATA_W-1:0] cb_data_1, cb_data_2;
  logic              stall_1, stall_2, grant_1, grant_2;
  logic              ex_or_shared_1, ex_or_shared_2;
  logic [DATA_W-1:0] fill_data;
  logic              mem_rd, main_mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [2:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];     // {core is 2, ex_or_shared, fill_data}
  logic [36:0] wb_exp_q[$];  // {mem_addr, mem_wdata}
  logic [DATA_W-1:0] mem [32];
  int cb_cnt = 0;
  int cb_seen = 0;
  bit resp_en = 1'b1;

  coherence_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .rd_intent_1(rd_intent_1), .rd_intent_2(rd_intent_2),
    .wr_intent_1(wr_intent_1), .wr_intent_2(wr_intent_2),
    .addr_core_1(addr_core_1), .addr_core_2(addr_core_2),
    .copy_back_1(copy_back_1), .copy_back_2(copy_back_2),
    .cb_ack_1(cb_ack_1), .cb_ack_2(cb_ack_2),
    .cb_data_1(cb_data_1), .cb_data_2(cb_data_2),
    .stall_1(stall_1), .stall_2(stall_2),
    .grant_1(grant_1), .grant_2(grant_2),
    .ex_or_shared_1(ex_or_shared_1), .ex_or_shared_2(ex_or_shared_2),
    .fill_data(fill_data), .mem_rd(mem_rd), .main_mem_wr(main_mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model, write-back checker and grant scoreboard
  always @(negedge clk) begin : mon
    logic [33:0] e;
    logic [36:0] w;
    if (main_mem_wr) begin
      if (wb_exp_q.size() == 0) check_val("wb_unexpected", main_mem_wr, 1'b0);
      else begin
        w = wb_exp_q.pop_front();
        check_val("wb_addr", mem_addr, w[36:32]);
        check_val("wb_data", mem_wdata, w[31:0]);
      end
      mem[mem_addr] = mem_wdata;
    end
    if (mem_rd) mem_rdata = mem[mem_addr];
    if (copy_back_2) check_val("cb2_unexpected", copy_back_2, 1'b0);
    if (grant_1 | grant_2) begin
      if (exp_q.size() == 0) check_val("grant_unexpected", {grant_2, grant_1}, 2'b00);
      else begin
        e = exp_q.pop_front();
        check_val("grant_core", {grant_2, grant_1}, e[33] ? 2'b10 : 2'b01);
        check_val("grant_ex", grant_2 ? ex_or_shared_2 : ex_or_shared_1, e[32]);
        check_val("grant_fill", fill_data, e[31:0]);
      end
    end
  end

  // Core 1 copy-back responder: acks on the third cycle it sees the recall
  always @(negedge clk) begin
    if (resp_en && copy_back_1) begin
      cb_cnt++;
      cb_seen++;
      if (cb_cnt == 3) begin
        cb_ack_1  = 1'b1;
        cb_data_1 = 32'hDEAD_BEEF;
      end
    end else begin
      cb_cnt   = 0;
      cb_ack_1 = 1'b0;
    end
  end

  task automatic set_intent(input int core, input bit wr, input logic [ADDR_W-1:0] a, input bit v);
    if (core == 1) begin
      rd_intent_1 = v & ~wr;
      wr_intent_1 = v & wr;
      addr_core_1 = a;
    end else begin
      rd_intent_2 = v & ~wr;
      wr_intent_2 = v & wr;
      addr_core_2 = a;
    end
  endtask

  task automatic push_exp(input int core, input bit ex, input logic [DATA_W-1:0] d);
    logic c2;
    c2 = (core == 2);
    exp_q.push_back({c2, ex, d});
  endtask

  task automatic wait_grant(input int core, input int max_cyc, output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check_val("stall_while_waiting", core == 1 ? stall_1 : stall_2, 1'b1);
      if ((core == 1 && grant_1) || (core == 2 && grant_2)) break;
      if (lat >= max_cyc) begin
        check_val("grant_timeout", {grant_2, grant_1}, core == 1 ? 2'b01 : 2'b10);
        break;
      end
    end
  endtask

  // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle
  task automatic run_req(input int core, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit ex, input int lat_exp,
                         input string tag);
    int lat;
    push_exp(core, ex, d);
    set_intent(core, wr, a, 1'b1);
    wait_grant(core, 60, lat);
    check_val({tag, "_lat"}, lat, lat_exp);
    @(negedge clk);
    set_intent(core, wr, a, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_both(input int first, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit ex_first, input bit ex_second, input string tag);
    int lat;
    int second;
    second = (first == 1) ? 2 : 1;
    push_exp(first, ex_first, d);
    push_exp(second, ex_second, d);
    set_intent(1, 1'b0, a, 1'b1);
    set_intent(2, 1'b0, a, 1'b1);
    wait_grant(first, 60, lat);
    check_val({tag, "_first_lat"}, lat, 4);
    check_val({tag, "_second_stalled"}, {stall_2, stall_1}, first == 1 ? 2'b10 : 2'b01);
    @(negedge clk);
    set_intent(first, 1'b0, a, 1'b0);
    wait_grant(second, 60, lat);
    check_val({tag, "_second_lat"}, lat, 5);
    @(negedge clk);
    set_intent(second, 1'b0, a, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d", dbg_state);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_intent_1 = 0; rd_intent_2 = 0; wr_intent_1 = 0; wr_intent_2 = 0;
    addr_core_1 = '0; addr_core_2 = '0;
    cb_ack_2 = 0; cb_data_2 = 32'h5555_5555; cb_data_1 = '0; cb_ack_1 = 0;
    mem_rdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hA5A5_0001;

    repeat (3) @(negedge clk);
    check_val("rst_state", dbg_state, 3'd0);
    check_val("rst_grant", {grant_2, grant_1}, 2'b00);
    check_val("rst_stall", {stall_2, stall_1}, 2'b00);
    check_val("rst_copy_back", {copy_back_2, copy_back_1}, 2'b00);
    check_val("rst_mem_strobes", {main_mem_wr, mem_rd}, 2'b00);
    check_val("rst_fill", fill_data, 32'h0);
    check_val("rst_ex", {ex_or_shared_2, ex_or_shared_1}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    run_req(1, 1'b0, 5'd5, 32'hA5A5_0001, 1'b1, 4, "c1_rd5");
    run_req(2, 1'b0, 5'd5, 32'hA5A5_0001, 1'b0, 4, "c2_rd5");
    cb_ack_2 = 1'b1;
    run_req(1, 1'b1, 5'd7, 32'h1000_0007, 1'b1, 4, "c1_wr7_stray_ack");
    cb_ack_2 = 1'b0;
    wb_exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    cb_seen = 0;
    run_req(2, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 8, "c2_rd7_recall");
    check_val("recall_cycles", cb_seen, 3);
    run_req(1, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 4, "c1_rd7_shared");

    // Fresh reset so the round-robin pointer starts at core 1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_both(1, 5'd9, 32'h1000_0009, 1'b1, 1'b0, "both9");
    run_both(1, 5'd12, 32'h1000_000C, 1'b1, 1'b0, "both12");
    run_req(1, 1'b0, 5'd20, 32'h1000_0014, 1'b1, 4, "c1_rd20");
    run_both(2, 5'd21, 32'h1000_0015, 1'b1, 1'b0, "both21");

    // Reset while a recall is outstanding
    run_req(1, 1'b1, 5'd13, 32'h1000_000D, 1'b1, 4, "c1_wr13");
    resp_en = 1'b0;
    set_intent(2, 1'b0, 5'd13, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_val("recall_active", copy_back_1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid_copy_back", {copy_back_2, copy_back_1}, 2'b00);
    check_val("rst_mid_stall", {stall_2, stall_1}, 2'b00);
    check_val("rst_mid_grant", {grant_2, grant_1}, 2'b00);
    check_val("rst_mid_state", dbg_state, 3'd0);
    set_intent(2, 1'b0, 5'd13, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    run_req(2, 1'b0, 5'd13, 32'h1000_000D, 1'b1, 4, "c2_rd13_after_rst");

    check_val("exp_q_drained", exp_q.size(), 0);
    check_val("wb_q_drained", wb_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
